// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the UART receive deframer.
package serial_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    localparam logic RX_IDLE_LEVEL = 1'b1;

    function automatic int bit_cnt_w(input int data_bits);
        return $clog2(data_bits + 1);
    endfunction

endpackage

// File: rtl/rx_sync.sv
// Multi-flop synchroniser for the raw serial line; resets to the idle level.
module rx_sync
    import serial_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= {SYNC_STAGES{RX_IDLE_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/serial_rx_deframer.sv
// UART receive framing controller: start detect, data shift, stop check.
// Build option SERIAL_RX_PARITY_EN adds an even-parity bit and parity_err output.
module serial_rx_deframer
    import serial_rx_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 sr_clk,
    output logic                 bsc_en,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 framing_err,
`ifdef SERIAL_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);

    localparam int CNT_W = bit_cnt_w(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state, state_nxt;
    logic                 bsc_en_nxt;
    logic [DATA_BITS-1:0] shreg;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 cnt_clr, shift_en, load_out, ferr_set;
`ifdef SERIAL_RX_PARITY_EN
    logic                 par_chk, par_bad;
`endif

    rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            bsc_en <= 1'b0;
        end else begin
            state  <= state_nxt;
            bsc_en <= bsc_en_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        load_out  = 1'b0;
        ferr_set  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        par_chk   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (rx_s != RX_IDLE_LEVEL) state_nxt = START;
            end
            START: begin
                if (sr_clk) begin
                    if (rx_s == RX_IDLE_LEVEL) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DATA;
                        cnt_clr   = 1'b1;
                    end
                end
            end
            DATA: begin
                if (sr_clk) begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            PARITY: begin
                if (sr_clk) begin
                    par_chk   = 1'b1;
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (sr_clk) begin
                    if (rx_s == RX_IDLE_LEVEL) begin
                        load_out  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr_set  = 1'b1;
                        state_nxt = WAIT_HIGH;
                    end
                end
            end
            // A held-low line (break) must go high before a new frame can start.
            WAIT_HIGH: begin
                if (rx_s == RX_IDLE_LEVEL) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        bsc_en_nxt = (state_nxt == START) || (state_nxt == DATA) ||
                     (state_nxt == PARITY) || (state_nxt == STOP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg       <= '0;
            bit_cnt     <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            data_valid  <= load_out;
            framing_err <= ferr_set;
            if (cnt_clr) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            // LSB arrives first, so shifting right leaves bit 0 at the bottom.
            if (shift_en) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (load_out) data_out <= shreg;
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (par_chk) par_bad <= rx_s ^ (^shreg);
            parity_err <= load_out & par_bad;
        end
    end
`endif

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_rx_deframer.sv
// Randomised self-checking bench for serial_rx_deframer with a 16x bit-sampling counter.
`timescale 1ns/1ps
module tb_serial_rx_deframer;

    localparam int DB = 8;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          rx = 1'b1;
    logic          sr_clk;
    logic          bsc_en;
    logic [DB-1:0] data_out;
    logic          data_valid;
    logic          framing_err;
    logic          busy;
`ifdef SERIAL_RX_PARITY_EN
    logic          parity_err;
`endif

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_rx_deframer #(.DATA_BITS(DB), .SYNC_STAGES(SS)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .sr_clk      (sr_clk),
        .bsc_en      (bsc_en),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .framing_err (framing_err),
`ifdef SERIAL_RX_PARITY_EN
        .parity_err  (parity_err),
`endif
        .busy        (busy)
    );

    // Bit-sampling counter: restarts while disabled, strobes mid-bit.
    logic [3:0] bsc_cnt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       bsc_cnt <= 4'd0;
        else if (!bsc_en) bsc_cnt <= 4'd0;
        else              bsc_cnt <= bsc_cnt + 4'd1;
    end
    assign sr_clk = bsc_en && (bsc_cnt == 4'd7);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Observed events
    logic [DB-1:0] got_q[$];
    logic          got_pe_q[$];
    int            fe_seen = 0, rise_seen = 0, excl_bad = 0, wide_bad = 0;
    logic          dv_d = 1'b0, fe_d = 1'b0, en_d = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            dv_d = 1'b0; fe_d = 1'b0; en_d = 1'b0;
        end else begin
            if (data_valid) begin
                got_q.push_back(data_out);
`ifdef SERIAL_RX_PARITY_EN
                got_pe_q.push_back(parity_err);
`endif
            end
            if (framing_err) fe_seen++;
            if (data_valid && framing_err) excl_bad++;
            if ((data_valid && dv_d) || (framing_err && fe_d)) wide_bad++;
            if (bsc_en && !en_d) rise_seen++;
            dv_d = data_valid; fe_d = framing_err; en_d = bsc_en;
        end
    end

    // Reference model: what each transmitted frame should produce
    logic [DB-1:0] exp_q[$];
    logic          exp_pe_q[$];
    int            fe_exp = 0, rise_exp = 0;
    logic [DB-1:0] last_good = '0;

    task automatic drive_bit(input logic b, input int n);
        rx = b;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop_ok,
                              input logic par_bit, input int stop_len, input bit meas);
        int lat;
        lat = 0;
        rx = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            if (bsc_en && lat == 0) lat = i;
        end
        if (meas) chk("start_lat", lat, SS + 1);
        for (int b = 0; b < DB; b++) drive_bit(d[b], 16);
`ifdef SERIAL_RX_PARITY_EN
        drive_bit(par_bit, 16);
`endif
        drive_bit(stop_ok, stop_len);
        rise_exp++;
        if (stop_ok) begin
            exp_q.push_back(d);
            exp_pe_q.push_back(par_bit ^ (^d));
            last_good = d;
        end else begin
            fe_exp++;
        end
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_cnt"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk({tag, "_data"}, got_q.pop_front(), exp_q.pop_front());
`ifdef SERIAL_RX_PARITY_EN
        while (got_pe_q.size() > 0 && exp_pe_q.size() > 0)
            chk({tag, "_perr"}, got_pe_q.pop_front(), exp_pe_q.pop_front());
`endif
        got_q.delete(); exp_q.delete(); got_pe_q.delete(); exp_pe_q.delete();
        chk({tag, "_ferr"}, fe_seen, fe_exp);
        chk({tag, "_rises"}, rise_seen, rise_exp);
        chk({tag, "_excl"}, excl_bad, 0);
        chk({tag, "_width"}, wide_bad, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DB-1:0] d;
        logic          ok;
        logic          pb;
        int            gap;
        bit            saw;

        // Reset state
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_bsc_en", bsc_en, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_dv", data_valid, 0);
        chk("rst_ferr", framing_err, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;
        drive_bit(1'b1, 10);

        // Good frame with start-latency measurement
        send_frame(8'hA5, 1'b1, ^8'hA5, 16, 1'b1);
        chk("good_busy", busy, 0);
        chk("good_out", data_out, 8'hA5);
        check_rx("good");
        drive_bit(1'b1, 8);

        // False start
        drive_bit(1'b0, 4);
        rx = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (bsc_en) saw = 1'b1;
        end
        rise_exp++;
        chk("fs_en_rose", saw, 1);
        chk("fs_en_low", bsc_en, 0);
        chk("fs_busy", busy, 0);
        check_rx("fs");

        // Framing error with a long low stop, then recovery
        send_frame(8'h3C, 1'b0, ^8'h3C, 40, 1'b0);
        chk("fe_en_held", bsc_en, 0);
        chk("fe_busy_wait", busy, 1);
        chk("fe_hold_out", data_out, last_good);
        drive_bit(1'b1, 6);
        chk("fe_busy_idle", busy, 0);
        check_rx("fe");
        send_frame(8'h81, 1'b1, ^8'h81, 16, 1'b1);
        drive_bit(1'b1, 4);
        check_rx("after_fe");

        // Back-to-back frames
        send_frame(8'h00, 1'b1, ^8'h00, 16, 1'b0);
        send_frame(8'hFF, 1'b1, ^8'hFF, 16, 1'b0);
        send_frame(8'h55, 1'b1, ^8'h55, 16, 1'b0);
        drive_bit(1'b1, 4);
        check_rx("b2b");

        // Reset mid-frame
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b0, 8);
        rise_exp++;
        reset = 1'b0;
        #1;
        chk("mr_bsc_en", bsc_en, 0);
        chk("mr_data_out", data_out, 0);
        chk("mr_dv", data_valid, 0);
        chk("mr_ferr", framing_err, 0);
        chk("mr_busy", busy, 0);
        last_good = '0;
        rx = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b1;
        drive_bit(1'b1, 6);
        send_frame(8'h12, 1'b1, ^8'h12, 16, 1'b1);
        chk("mr_out", data_out, 8'h12);
        drive_bit(1'b1, 4);
        check_rx("mr");

`ifdef SERIAL_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 16, 1'b0);
        send_frame(8'h07, 1'b1, 1'b0, 16, 1'b0);
        drive_bit(1'b1, 4);
        check_rx("par");
`endif

        // Randomised frames, gaps and stop errors
        for (int k = 0; k < 24; k++) begin
            d   = DB'($urandom_range(0, 255));
            ok  = ($urandom_range(0, 4) != 0);
            pb  = (^d) ^ ($urandom_range(0, 3) == 0);
            send_frame(d, ok, pb, ok ? 16 : 16 + int'($urandom_range(0, 20)), 1'b0);
            gap = ok ? int'($urandom_range(0, 12)) : int'($urandom_range(2, 12));
            drive_bit(1'b1, gap);
        end
        drive_bit(1'b1, 6);
        chk("rnd_hold", data_out, last_good);
        chk("rnd_busy", busy, 0);
        check_rx("rnd");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_rx_deframer.md
Name: serial_rx_deframer

Overview:
Receive-side framing controller placed directly downstream of the bit-sampling counter in the UART receive path.
- Watches the serial line and detects the start bit.
- Drives the counter's enable input (bsc_en) and consumes its one-cycle mid-bit strobe (sr_clk).
- Shifts in the data bits, checks the stop bit, and presents a parallel byte with a valid pulse or a framing-error pulse.
- clk is the same 16x oversample clock that the bit-sampling counter uses.

Parameters:
- DATA_BITS, 8, number of data bits per frame, sent LSB first; legal range 5..9.
- SYNC_STAGES, 2, depth of the rx input synchroniser; minimum 2.

Ports:
- clk  in  1  16x oversample clock.
- reset  in  1  asynchronous, active-low reset.
- rx  in  1  raw serial line; idles high.
- sr_clk  in  1  one-cycle mid-bit strobe from the bit-sampling counter.
- bsc_en  out  1  enable to the bit-sampling counter, registered.
- data_out  out  DATA_BITS  last good received word, held until the next good frame.
- data_valid  out  1  one-cycle pulse when data_out is updated.
- framing_err  out  1  one-cycle pulse when the stop bit is sampled low.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0; state = IDLE.
  - Synchroniser flops preset to 1 (line idle).
  - Bit counter and shift register cleared.
- rx passes through SYNC_STAGES flops to give rx_s. All decisions use rx_s only.
- States:
  - IDLE: bsc_en=0. When rx_s=0, go to START and set bsc_en=1 on the same edge.
  - START: wait for sr_clk.
    - sr_clk with rx_s=0: go to DATA; bit counter = 0.
    - sr_clk with rx_s=1: false start. Go to IDLE; bsc_en=0.
  - DATA: on each sr_clk, shift rx_s into the MSB of the shift register (shift right) and increment the bit counter. On the sr_clk that samples bit DATA_BITS-1, go to STOP (or to PARITY if the optional feature is enabled).
  - STOP: on sr_clk:
    - rx_s=1: data_out <= shift register; data_valid=1 on the next cycle; go to IDLE; bsc_en=0.
    - rx_s=0: framing_err=1 on the next cycle; data_out unchanged; go to WAIT_HIGH; bsc_en=0.
  - WAIT_HIGH: bsc_en=0; stay until rx_s=1, then go to IDLE. This prevents a break condition from re-triggering a frame.
- bsc_en must be low for at least one clk between frames. Returning through IDLE guarantees this, so the counter restarts at 0 for every frame.
- Timing:
  - Start-edge latency: rx falling edge to bsc_en high is SYNC_STAGES+1 clk.
  - Each bit is sampled on the single clk where sr_clk=1.
  - sr_clk arriving in IDLE or WAIT_HIGH is ignored.
- data_valid and framing_err are mutually exclusive, each exactly one clk wide.
- Back-to-back frames: a start bit that begins immediately after a good stop bit is accepted. IDLE is left one clk after rx_s goes low.
- Reset asserted mid-frame: immediate return to IDLE. The partial word is discarded with no pulse, and data_out is cleared.

Optional Feature:
- Macro: SERIAL_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP.
  - On sr_clk the sampled bit is XORed with the reduction-XOR of the shift register; even parity is expected.
  - Adds output parity_err (1 bit). It pulses with data_valid when parity mismatches; data_out still updates.
- Undefined:
  - No PARITY state and no parity_err port.
  - Frame = start + DATA_BITS + stop.

Decomposition:
- Package serial_rx_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - constant RX_IDLE_LEVEL = 1'b1;
  - a bit-counter width function, $clog2(DATA_BITS+1).
- One sub-module, rx_sync: a SYNC_STAGES-deep synchroniser with asynchronous active-low reset presetting to 1.

Test Plan:
The bench instantiates the real bit-sampling counter, driven by bsc_en, so each bit period is 16 clk.
- Good frame: send 0xA5 (LSB first, start 0, stop 1) -> one data_valid pulse, data_out=0xA5, framing_err never set, busy low after the stop-bit sr_clk.
- False start: rx low for 4 clk then high -> bsc_en rises then falls at the first sr_clk; no data_valid, no framing_err, state back to IDLE.
- Framing error: send 0x3C with stop bit 0, held low for 40 clk -> framing_err for 1 clk, data_out keeps its previous value, bsc_en stays 0 until rx returns high; the next good 0x81 is received correctly.
- Back-to-back: 0x00, 0xFF, 0x55 with no idle gap -> three data_valid pulses, values in order, bsc_en low for at least 1 clk between frames.
- Reset mid-frame: assert reset after 3 data bits of 0xC3 -> all outputs 0 immediately; after release, the next 0x12 is received with data_valid and data_out=0x12.
- SERIAL_RX_PARITY_EN build: 0x07 with parity bit 1 -> data_valid, parity_err=0; 0x07 with parity bit 0 -> data_valid with parity_err=1.
